// File: rtl/voice_scheduler.sv
// Assigns note-on/off events to three tone voices: retrigger on a hit, allocate a free voice, or steal the oldest.
// Each event takes three cycles (accept, lookup, update); all outputs except event_ready are registered.
module voice_scheduler #(
  parameter int SPLIT_NOTE = 60
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       event_valid,
  output logic       event_ready,
  input  logic       event_on,
  input  logic [6:0] event_note,
  input  logic       pan_alternate,
  input  logic       all_notes_off,
  output logic [2:0] voice_active,
  output logic [6:0] voice_note_a,
  output logic [6:0] voice_note_b,
  output logic [6:0] voice_note_c,
  output logic [2:0] voice_pan,
  output logic [2:0] voice_trig,
  output logic       voice_steal
);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;
  typedef enum logic [2:0] {ACT_NONE, ACT_RETRIG, ACT_ALLOC, ACT_STEAL, ACT_OFF} act_t;

  state_t     state, state_nxt;
  act_t       act_q, act_nxt;
  logic [1:0] tgt_q, tgt_nxt;
  logic [6:0] note_q;
  logic       on_q, alt_q;
  logic [6:0] note_r [3];
  logic [1:0] rank [3];
  logic       toggle;

  logic       hit, free_any;
  logic [1:0] hit_idx, free_idx, old_idx;
  logic [1:0] tgt_rank;
  logic       start, fresh, new_pan;

  assign event_ready  = rst_n && (state == IDLE);
  assign voice_note_a = note_r[0];
  assign voice_note_b = note_r[1];
  assign voice_note_c = note_r[2];

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (event_valid) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (all_notes_off) state_nxt = IDLE;
  end

  // Descending scan so the lowest-index match / free voice wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 2'd0;
    free_any = 1'b0;
    free_idx = 2'd0;
    old_idx  = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (voice_active[i] && note_r[i] == note_q) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (!voice_active[i]) begin
        free_any = 1'b1;
        free_idx = 2'(i);
      end
      if (voice_active[i] && rank[i] == 2'd2) old_idx = 2'(i);
    end
    act_nxt = ACT_NONE;
    tgt_nxt = 2'd0;
    if (on_q) begin
      if (hit) begin
        act_nxt = ACT_RETRIG;
        tgt_nxt = hit_idx;
      end else if (free_any) begin
        act_nxt = ACT_ALLOC;
        tgt_nxt = free_idx;
      end else begin
        act_nxt = ACT_STEAL;
        tgt_nxt = old_idx;
      end
    end else if (hit) begin
      act_nxt = ACT_OFF;
      tgt_nxt = hit_idx;
    end
  end

  // A free target counts as rank 3, so allocation ages every active voice.
  always_comb begin
    tgt_rank = 2'd3;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) == tgt_q && voice_active[i]) tgt_rank = rank[i];
    end
    start   = (act_q == ACT_RETRIG) || (act_q == ACT_ALLOC) || (act_q == ACT_STEAL);
    fresh   = (act_q == ACT_ALLOC) || (act_q == ACT_STEAL);
    new_pan = alt_q ? toggle : (int'(note_q) < SPLIT_NOTE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      voice_active <= '0;
      voice_pan    <= '0;
      voice_trig   <= '0;
      voice_steal  <= 1'b0;
      toggle       <= 1'b0;
      note_r       <= '{default: '0};
      rank         <= '{default: '0};
      act_q        <= ACT_NONE;
      tgt_q        <= 2'd0;
      note_q       <= '0;
      on_q         <= 1'b0;
      alt_q        <= 1'b0;
    end else begin
      voice_trig  <= '0;
      voice_steal <= 1'b0;
      if (all_notes_off) begin
        voice_active <= '0;
        rank         <= '{default: '0};
      end else begin
        if (event_valid && event_ready) begin
          note_q <= event_note;
          on_q   <= event_on;
          alt_q  <= pan_alternate;
        end
        if (state == LOOKUP) begin
          act_q <= act_nxt;
          tgt_q <= tgt_nxt;
        end
        if (state == UPDATE) begin
          for (int i = 0; i < 3; i++) begin
            if (2'(i) == tgt_q) begin
              if (start) begin
                voice_active[i] <= 1'b1;
                rank[i]         <= 2'd0;
                voice_trig[i]   <= 1'b1;
              end else if (act_q == ACT_OFF) begin
                voice_active[i] <= 1'b0;
                rank[i]         <= 2'd0;
              end
              if (fresh) begin
                note_r[i]    <= note_q;
                voice_pan[i] <= new_pan;
              end
            end else if (voice_active[i]) begin
              if (start && rank[i] < tgt_rank) rank[i] <= rank[i] + 2'd1;
              if (act_q == ACT_OFF && rank[i] > tgt_rank) rank[i] <= rank[i] - 2'd1;
            end
          end
          if (fresh && alt_q) toggle <= ~toggle;
          voice_steal <= (act_q == ACT_STEAL);
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: directed scenarios plus random events against an age-queue reference model.
module tb_voice_scheduler;
  localparam int SPLIT = 60;

  logic       clk = 1'b0;
  logic       rst_n, event_valid, event_ready, event_on, pan_alternate, all_notes_off;
  logic [6:0] event_note;
  logic [2:0] voice_active, voice_pan, voice_trig;
  logic [6:0] voice_note_a, voice_note_b, voice_note_c;
  logic       voice_steal;

  voice_scheduler #(.SPLIT_NOTE(SPLIT)) dut (
    .clk_in(clk), .rst_n(rst_n), .event_valid(event_valid), .event_ready(event_ready),
    .event_on(event_on), .event_note(event_note), .pan_alternate(pan_alternate),
    .all_notes_off(all_notes_off), .voice_active(voice_active),
    .voice_note_a(voice_note_a), .voice_note_b(voice_note_b), .voice_note_c(voice_note_c),
    .voice_pan(voice_pan), .voice_trig(voice_trig), .voice_steal(voice_steal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: per-voice state plus a queue of voice indices, newest first.
  bit       m_act [3];
  int       m_note[3];
  bit       m_pan [3];
  bit       m_tog;
  int       age[$];
  bit [2:0] exp_trig;
  bit       exp_steal;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void age_remove(int v);
    for (int k = 0; k < age.size(); k++) begin
      if (age[k] == v) begin
        age.delete(k);
        return;
      end
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_pan[i] = 0;
    end
    m_tog = 0; age.delete(); exp_trig = 0; exp_steal = 0;
  endfunction

  function automatic void m_panic();
    for (int i = 0; i < 3; i++) m_act[i] = 0;
    age.delete(); exp_trig = 0; exp_steal = 0;
  endfunction

  function automatic void m_apply(bit on, int n, bit alt);
    int  v;
    bit  fresh;
    v = -1;
    exp_trig = 0;
    exp_steal = 0;
    for (int i = 0; i < 3; i++) if (v < 0 && m_act[i] && m_note[i] == n) v = i;
    if (on) begin
      fresh = (v < 0);
      if (v < 0) for (int i = 0; i < 3; i++) if (v < 0 && !m_act[i]) v = i;
      if (v < 0) begin
        v = age[age.size() - 1];
        exp_steal = 1;
      end
      if (fresh) begin
        m_note[v] = n;
        m_pan[v]  = alt ? m_tog : (n < SPLIT);
        if (alt) m_tog = ~m_tog;
      end
      m_act[v] = 1;
      age_remove(v);
      age.push_front(v);
      exp_trig[v] = 1'b1;
    end else if (v >= 0) begin
      m_act[v] = 0;
      age_remove(v);
    end
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_active"}, voice_active, {m_act[2], m_act[1], m_act[0]});
    chk({tag, "_note_a"}, voice_note_a, m_note[0]);
    chk({tag, "_note_b"}, voice_note_b, m_note[1]);
    chk({tag, "_note_c"}, voice_note_c, m_note[2]);
    chk({tag, "_pan"},    voice_pan,    {m_pan[2], m_pan[1], m_pan[0]});
    chk({tag, "_trig"},   voice_trig,   exp_trig);
    chk({tag, "_steal"},  voice_steal,  exp_steal);
  endtask

  // Called at a negedge; returns at the negedge of the cycle where the response is visible.
  task automatic send(input bit on, input int n, input bit alt);
    int w;
    w = 0;
    while (!event_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!event_ready) begin
      chk("ready_timeout", event_ready, 1);
      return;
    end
    event_valid = 1; event_on = on; event_note = 7'(n); pan_alternate = alt;
    @(posedge clk);
    m_apply(on, n, alt);
    @(negedge clk);
    event_valid = 0;
    chk("busy1_ready", event_ready, 0);
    chk("busy1_trig", voice_trig, 0);
    @(negedge clk);
    chk("busy2_ready", event_ready, 0);
    chk("busy2_trig", voice_trig, 0);
    @(negedge clk);
    chk("resp_ready", event_ready, 1);
    check_state("ev");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    rst_n = 0; event_valid = 0; event_on = 0; event_note = 0;
    pan_alternate = 0; all_notes_off = 0;
    m_reset();
    @(negedge clk);
    chk("rst_ready", event_ready, 0);
    @(negedge clk);
    check_state("rst");
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", event_ready, 1);

    // Fill three voices in alternate mode, then steal.
    send(1, 60, 1); chk("tp_trig_a", voice_trig, 3'b001);
    send(1, 64, 1); chk("tp_trig_b", voice_trig, 3'b010);
    send(1, 67, 1); chk("tp_trig_c", voice_trig, 3'b100);
    chk("tp_pan3", voice_pan, 3'b010);
    send(1, 72, 1);
    chk("tp_steal", voice_steal, 1);
    chk("tp_steal_trig", voice_trig, 3'b001);
    chk("tp_steal_note", voice_note_a, 72);
    @(negedge clk);
    chk("tp_steal_pulse", voice_steal, 0);
    exp_trig = 0; exp_steal = 0;
    send(0, 64, 1);
    chk("tp_off_b", voice_active, 3'b101);
    send(1, 50, 0);
    chk("tp_split_note", voice_note_b, 50);
    chk("tp_split_pan", voice_pan[1], 1);
    chk("tp_split_nosteal", voice_steal, 0);
    send(1, 67, 1);
    chk("tp_retrig", voice_trig, 3'b100);
    chk("tp_retrig_pan", voice_pan[2], 0);
    send(1, 80, 1);
    chk("tp_oldest_steal", voice_trig, 3'b001);
    send(0, 99, 1);

    // Valid held through busy cycles: one accept per three cycles.
    exp_trig = 0; exp_steal = 0;
    event_valid = 1; event_on = 0; event_note = 7'd99; pan_alternate = 0;
    n_acc = 0;
    for (int c = 0; c < 9; c++) begin
      if (event_ready) n_acc++;
      @(negedge clk);
    end
    event_valid = 0;
    chk("hold_accepts", n_acc, 3);
    @(negedge clk);
    @(negedge clk);
    check_state("hold");

    // Panic during LOOKUP drops the event.
    event_valid = 1; event_on = 1; event_note = 7'd40; pan_alternate = 1;
    @(posedge clk);
    @(negedge clk);
    event_valid = 0; all_notes_off = 1;
    @(negedge clk);
    all_notes_off = 0;
    m_panic();
    chk("panic_active", voice_active, 0);
    chk("panic_trig", voice_trig, 0);
    chk("panic_ready", event_ready, 1);
    @(negedge clk);
    check_state("panic");

    // Random events against the model, with occasional panics.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        all_notes_off = 1;
        @(negedge clk);
        all_notes_off = 0;
        m_panic();
        check_state("rnd_panic");
      end else begin
        send($urandom_range(0, 9) < 6, 40 + int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      end
    end

    // Reset during UPDATE.
    send(1, 41, 1);
    send(1, 43, 0);
    event_valid = 1; event_on = 1; event_note = 7'd45; pan_alternate = 1;
    @(posedge clk);
    @(negedge clk);
    event_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    m_reset();
    check_state("midrst");
    chk("midrst_ready", event_ready, 0);
    rst_n = 1;
    @(negedge clk);
    chk("midrst_ready_after", event_ready, 1);
    send(1, 70, 1);
    chk("midrst_pan_right", voice_pan, 3'b000);
    chk("midrst_alloc_a", voice_trig, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Allocates incoming note-on/note-off events to the three tone-generator voices (a, b, c) that feed the stereo sample mixer, and chooses each voice's pan bit. Each voice's tone generator appends `voice_pan[i]` as bit 0 of its 17-bit note word: 1 = left, 0 = right. The block owns the voice state: free/active status, note number, age order and pan. When all voices are busy it steals the oldest voice.

## Interface
- `SPLIT_NOTE`, default 60: in split pan mode, notes below this value pan left and the rest pan right.
- `clk_in` input 1: system clock.
- `rst_n` input 1: synchronous, active-low reset.
- `event_valid` input 1: an event is presented.
- `event_ready` output 1: the block can accept an event this cycle.
- `event_on` input 1: 1 = note-on, 0 = note-off.
- `event_note` input 7: note number, 0–127.
- `pan_alternate` input 1: 1 = alternate pan per new allocation; 0 = split pan by `SPLIT_NOTE`.
- `all_notes_off` input 1: panic; clears every voice.
- `voice_active` output 3: bit i = voice i sounding (0 = a, 1 = b, 2 = c).
- `voice_note_a`, `voice_note_b`, `voice_note_c` output 7 each: note number of each voice.
- `voice_pan` output 3: pan bit per voice.
- `voice_trig` output 3: one-cycle pulse when a voice is (re)started; the tone generator resets its phase on this pulse.
- `voice_steal` output 1: one-cycle pulse coincident with `voice_trig` when an active voice was stolen.

## Operation
- Handshake:
  - `event_ready` = `rst_n` && (state == IDLE).
  - An event is accepted on a clock edge where `event_valid` && `event_ready` are both high; the note, on-flag and `pan_alternate` are latched at that edge.
- States:
  - IDLE: on accept → LOOKUP.
  - LOOKUP: compare the latched note with every active voice; compute the free voice and the oldest voice; register the chosen target and action → UPDATE.
  - UPDATE: write the voice registers and pulse the outputs → IDLE.
- Age ranks:
  - Each voice holds a 2-bit rank; active voices always hold distinct ranks 0..k-1, where 0 = newest.
  - A free voice is treated as rank 3.
- Note-on, hit (the note matches an active voice):
  - Retrigger that voice: `voice_trig` pulse.
  - Its rank becomes 0, and active voices with a lower rank increment.
  - Pan is unchanged and the pan toggle does not flip.
- Note-on, miss with a free voice available:
  - Allocate the lowest-index free voice.
  - Its rank becomes 0 and all other active voices increment.
  - Pan is assigned, then `voice_trig` pulses.
- Note-on, miss with all voices active:
  - Steal the voice with rank 2; new note, new pan.
  - Rank update is the same as for a hit.
  - `voice_trig` and `voice_steal` pulse together.
- Pan assignment, on new allocations only (free or stolen):
  - With `pan_alternate` = 1, pan = toggle register, which then inverts. The toggle resets to 0, so the first note goes right.
  - With `pan_alternate` = 0, pan = (note < `SPLIT_NOTE`), and the toggle is untouched.
- Note-off, match:
  - Clear that voice's active bit.
  - Active voices with a higher rank decrement.
  - The voice's note and pan registers hold their last values; no pulse is produced.
- Note-off, no match: the event is consumed with no state change and no pulse.
- `all_notes_off`:
  - At the next edge, clear all active bits and ranks and drop any in-flight event; state returns to IDLE.
  - No pulses are produced.
  - It has priority over event processing but is lower priority than reset.
  - The pan toggle is kept.
- Reset, while `rst_n` is low at an edge:
  - state = IDLE; `voice_active` = 0; all notes = 0; `voice_pan` = 0; ranks = 0; pan toggle = 0.
  - `voice_trig` = 0 and `voice_steal` = 0.
  - `event_ready` is 0 combinationally while `rst_n` is low.
  - Reset mid-event discards the event.

## Timing
- Accept at edge E0 → LOOKUP during cycle 1 → UPDATE during cycle 2 → voice registers and pulses update at edge E2 and are visible in cycle 3.
- `event_ready` is low in cycles 1–2 and high again in cycle 3.
- Throughput is one event per 3 cycles.
- `voice_trig` and `voice_steal` are registered and high for exactly one cycle.
- All outputs are registered except `event_ready`.
- Pan output changes coincide with `voice_trig`.

## Test plan
- Reset, then note-on 60, 64, 67 in alternate mode:
  - Required: voices a, b, c take 60, 64, 67; `voice_pan` = 3'b010; trig pulses 001, 010, 100.
  - Required: each event's response lands 3 cycles after accept.
- Fourth note-on, 72, with all voices active: voice a is stolen (note 72, pan 1); `voice_trig` = 001 and `voice_steal` = 1 for one cycle.
- Note-off 64: b becomes inactive; a following note-on 50 in split mode (`SPLIT_NOTE` = 60) allocates b with pan 1 and no steal.
- Note-on 67 while 67 is sounding on c: `voice_trig` = 100 with pan unchanged; the next steal then picks the voice that is oldest after this retrigger.
- Note-off 99 (not sounding): accepted after one handshake, no output change, `event_ready` high again 3 cycles later.
- Protocol edge cases:
  - Assert `all_notes_off` in the LOOKUP cycle: `voice_active` = 0 next cycle, no trig, `event_ready` high the following cycle.
  - Hold `event_valid` high during busy cycles: only one accept per 3 cycles.
  - Drop `rst_n` during UPDATE: no pulse, all outputs zero.
